// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl
// Brief    : Programmable interrupt controller. It latches per-source requests
//            in edge or level mode, masks them, and drives registered HWInt
//            plus a priority claim ID.
// Revision : 1.0 - initial release
// ============================================================================
module int_ctrl #(
    parameter int          NSRC       = 6,
    parameter logic [5:0]  RESET_MASK = 6'h00,
    parameter logic [5:0]  RESET_MODE = 6'h00
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic [1:0]      Addr,
    input  logic            We,
    input  logic [31:0]     WD,
    output logic [31:0]     RD,
    output logic [5:0]      HWInt,
    output logic [2:0]      irq_id
);

    localparam logic [1:0] c_ADDR_PEND  = 2'b00;
    localparam logic [1:0] c_ADDR_MASK  = 2'b01;
    localparam logic [1:0] c_ADDR_MODE  = 2'b10;
    localparam logic [1:0] c_ADDR_CLAIM = 2'b11;
    localparam logic [2:0] c_NO_IRQ     = 3'd7;

    logic [NSRC-1:0] r_src_q;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_mode;
    logic [NSRC-1:0] r_hwint;
    logic [2:0]      r_irq_id;

    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_active;
    logic [2:0]      w_id_nxt;
    logic            w_unused;

    // Write-data bits above the source count carry no meaning.
    assign w_unused = &{1'b0, WD[31:NSRC]};

    assign w_edge = irq_src & ~r_src_q;

    // Edge bits: a new event takes priority over a same-cycle CLEAR. Level bits track the input.
    always_comb begin
        w_clr = '0;
        if (We && (Addr == c_ADDR_CLAIM)) begin
            w_clr = WD[NSRC-1:0];
        end
        w_pend_nxt = (r_mode & (w_edge | (r_pend & ~w_clr))) | (~r_mode & irq_src);
    end

    assign w_active = r_pend & r_mask;

    // Scan from high index to low so the lowest active index wins.
    always_comb begin
        w_id_nxt = c_NO_IRQ;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_id_nxt = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src_q  <= '0;
            r_pend   <= '0;
            r_mask   <= RESET_MASK[NSRC-1:0];
            r_mode   <= RESET_MODE[NSRC-1:0];
            r_hwint  <= '0;
            r_irq_id <= c_NO_IRQ;
        end else begin
            r_src_q  <= irq_src;
            r_pend   <= w_pend_nxt;
            r_hwint  <= w_active;
            r_irq_id <= w_id_nxt;
            if (We && (Addr == c_ADDR_MASK)) begin
                r_mask <= WD[NSRC-1:0];
            end
            if (We && (Addr == c_ADDR_MODE)) begin
                r_mode <= WD[NSRC-1:0];
            end
        end
    end

    always_comb begin
        RD = '0;
        case (Addr)
            c_ADDR_PEND:  RD = 32'(r_pend);
            c_ADDR_MASK:  RD = 32'(r_mask);
            c_ADDR_MODE:  RD = 32'(r_mode);
            c_ADDR_CLAIM: RD = {(|r_hwint), 28'b0, r_irq_id};
            default:      RD = '0;
        endcase
    end

    assign HWInt  = 6'(r_hwint);
    assign irq_id = r_irq_id;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_ctrl
// Brief    : Directed self-checking bench for int_ctrl with hand-computed
//            expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

    localparam logic [1:0] c_PEND  = 2'b00;
    localparam logic [1:0] c_MASK  = 2'b01;
    localparam logic [1:0] c_MODE  = 2'b10;
    localparam logic [1:0] c_CLAIM = 2'b11;

    logic        clk;
    logic        rst;
    logic [5:0]  irq_src;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] WD;
    logic [31:0] RD;
    logic [5:0]  HWInt;
    logic [2:0]  irq_id;

    int total;
    int bad;

    int_ctrl #(
        .NSRC       (6),
        .RESET_MASK (6'h00),
        .RESET_MODE (6'h00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .Addr    (Addr),
        .We      (We),
        .WD      (WD),
        .RD      (RD),
        .HWInt   (HWInt),
        .irq_id  (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        Addr = a;
        #1;
        chk(tag, RD, exp);
    endtask

    // Issues one write strobe; returns on the falling edge after the write edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        WD   = d;
        We   = 1'b1;
        @(negedge clk);
        We   = 1'b0;
        WD   = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        We      = 1'b0;
        Addr    = c_PEND;
        WD      = '0;
        irq_src = 6'($urandom);

        // Reset state with arbitrary requests present
        step(2);
        chk("rst_hwint", 32'(HWInt), 32'h0);
        chk("rst_irq_id", 32'(irq_id), 32'h7);
        rd(c_PEND, "rst_pend", 32'h0);
        rd(c_MASK, "rst_mask", 32'h0);
        rd(c_MODE, "rst_mode", 32'h0);
        irq_src = 6'h02;
        rst     = 1'b1;
        step(1);
        rd(c_PEND, "level_after_release", 32'h2);
        chk("level_masked_hwint", 32'(HWInt), 32'h0);
        irq_src = 6'h00;
        step(1);
        rd(c_PEND, "level_follows_drop", 32'h0);

        // Edge latch on source 0
        wr(c_MODE, 32'h1);
        wr(c_MASK, 32'h1);
        rd(c_MODE, "mode_rb", 32'h1);
        irq_src = 6'h01;
        step(1);
        irq_src = 6'h00;
        rd(c_PEND, "edge_pend_1edge", 32'h1);
        chk("edge_hwint_1edge", 32'(HWInt), 32'h0);
        step(1);
        chk("edge_hwint_2edge", 32'(HWInt), 32'h01);
        chk("edge_id_2edge", 32'(irq_id), 32'h0);
        step(1);
        rd(c_PEND, "edge_pend_held", 32'h1);
        wr(c_CLAIM, 32'h1);
        rd(c_PEND, "clr_pend_drop", 32'h0);
        chk("clr_hwint_still", 32'(HWInt), 32'h01);
        step(1);
        chk("clr_hwint_drop", 32'(HWInt), 32'h0);
        chk("clr_id_none", 32'(irq_id), 32'h7);

        // Priority between sources 3 and 5
        wr(c_MODE, 32'h3F);
        wr(c_MASK, 32'h3F);
        irq_src = 6'h28;
        step(1);
        irq_src = 6'h00;
        step(1);
        chk("prio_hwint", 32'(HWInt), 32'h28);
        chk("prio_id3", 32'(irq_id), 32'h3);
        rd(c_CLAIM, "claim_3", 32'h8000_0003);
        wr(c_CLAIM, 32'h08);
        step(1);
        chk("prio_id5", 32'(irq_id), 32'h5);
        rd(c_CLAIM, "claim_5", 32'h8000_0005);
        wr(c_CLAIM, 32'h20);
        step(1);
        rd(c_CLAIM, "claim_none", 32'h0000_0007);
        chk("prio_hwint_none", 32'(HWInt), 32'h0);

        // Same-cycle edge event and CLEAR on source 2
        irq_src = 6'h04;
        Addr    = c_CLAIM;
        WD      = 32'h4;
        We      = 1'b1;
        step(1);
        We      = 1'b0;
        WD      = '0;
        irq_src = 6'h00;
        rd(c_PEND, "collide_set_wins", 32'h4);
        wr(c_CLAIM, 32'h4);
        step(1);
        rd(c_PEND, "collide_cleared", 32'h0);
        chk("collide_hwint", 32'(HWInt), 32'h0);

        // Masking, then CLEAR on a level bit and an edge->level switch
        wr(c_MASK, 32'h0);
        irq_src = 6'h10;
        step(1);
        irq_src = 6'h00;
        rd(c_PEND, "masked_pend", 32'h10);
        step(1);
        chk("masked_hwint", 32'(HWInt), 32'h0);
        chk("masked_id", 32'(irq_id), 32'h7);
        wr(c_MASK, 32'h10);
        chk("unmask_same_edge", 32'(HWInt), 32'h0);
        step(1);
        chk("unmask_hwint", 32'(HWInt), 32'h10);
        chk("unmask_id", 32'(irq_id), 32'h4);
        wr(c_MODE, 32'h3D);
        irq_src = 6'h02;
        step(1);
        rd(c_PEND, "level_bit1_set", 32'h12);
        wr(c_CLAIM, 32'h2);
        rd(c_PEND, "level_clear_ignored", 32'h12);
        wr(c_MODE, 32'h2D);
        rd(c_PEND, "mode_switch_edge", 32'h12);
        step(1);
        rd(c_PEND, "stale_latch_dropped", 32'h02);
        irq_src = 6'h00;

        // Asynchronous reset while an interrupt is being serviced
        wr(c_MASK, 32'h1);
        irq_src = 6'h01;
        step(1);
        irq_src = 6'h00;
        step(1);
        chk("svc_hwint", 32'(HWInt), 32'h01);
        #2;
        rst = 1'b0;
        #1;
        chk("async_hwint", 32'(HWInt), 32'h0);
        chk("async_id", 32'(irq_id), 32'h7);
        rd(c_MASK, "async_mask", 32'h0);
        rd(c_PEND, "async_pend", 32'h0);
        step(1);
        rst = 1'b1;
        step(1);
        chk("post_reset_hwint", 32'(HWInt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
